// File: rtl/uart_rx_frontend.sv
// ============================================================================
// Module   : uart_rx_frontend
// Purpose  : 8N1 serial receiver with byte handshake, glitch/framing/overrun
//            reporting for the CPU UART peripheral.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_frontend #(
  parameter int CLKS_PER_BIT = 1302,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       UART_RX,
  input  logic       rx_ack,
  input  logic       err_clr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             sync_ff;
  logic             rx_s;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             baud_done;
  logic             cnt_run;
  logic             sample_data;
  logic             stop_good;
  logic             stop_bad;
  logic             commit;
  logic             ovr_set;

  // Synchroniser resets to the idle (high) line level so reset never fakes a start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_ff <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync_ff <= UART_RX;
      rx_s    <= sync_ff;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_run     = 1'b0;
    sample_data = 1'b0;
    stop_good   = 1'b0;
    stop_bad    = 1'b0;
    baud_done   = (state == START) ? (baud_cnt == HALF_LAST) : (baud_cnt == BIT_LAST);
    case (state)
      IDLE: begin
        if (!rx_s) state_nxt = START;
      end
      START: begin
        cnt_run = 1'b1;
        if (baud_done) state_nxt = rx_s ? IDLE : DATA;
      end
      DATA: begin
        cnt_run = 1'b1;
        if (baud_done) begin
          sample_data = 1'b1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        cnt_run = 1'b1;
        if (baud_done) begin
          if (rx_s) begin
            stop_good = 1'b1;
            state_nxt = IDLE;
          end else begin
            stop_bad  = 1'b1;
            state_nxt = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A same-cycle ack frees the holding register, so the new byte wins.
    commit  = stop_good && (!rx_valid || rx_ack);
    ovr_set = stop_good && rx_valid && !rx_ack;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      baud_cnt <= (cnt_run && !baud_done) ? baud_cnt + 1'b1 : '0;
      if (sample_data) begin
        bit_idx   <= bit_idx + 3'd1;
        shift_reg <= {rx_s, shift_reg[7:1]};
      end else if (state != DATA) begin
        bit_idx <= '0;
      end
      if (commit) begin
        rx_data  <= shift_reg;
        rx_valid <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
      if (stop_bad)     frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (ovr_set)      overrun <= 1'b1;
      else if (err_clr) overrun <= 1'b0;
    end
  end

  assign busy = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_frontend.sv
// ============================================================================
// Module   : tb_uart_rx_frontend
// Purpose  : Scoreboard bench for uart_rx_frontend with a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_frontend;

  localparam int CPB    = 16;
  localparam int HALF   = CPB / 2;
  localparam int ACK_AT = 2 + HALF + 9 * CPB;

  typedef struct packed {
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       ovr;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       UART_RX = 1'b1;
  logic       rx_ack = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int   checks = 0;
  int   failures = 0;
  exp_t expq[$];

  // Frame-level reference state
  logic [7:0] m_data = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_ferr = 1'b0;
  logic       m_ovr = 1'b0;

  uart_rx_frontend #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .UART_RX(UART_RX), .rx_ack(rx_ack), .err_clr(err_clr),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.data  = m_data;
    e.valid = m_valid;
    e.ferr  = m_ferr;
    e.ovr   = m_ovr;
    return e;
  endfunction

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic pulse_ack();
    rx_ack = 1'b1;
    @(posedge clk); #1;
    rx_ack = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
  endtask

  task automatic bit_time(input int n);
    repeat (n * CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int stop_low, input bit ack_hit,
                            input int gap);
    if (stop_low == 0) begin
      if (!m_valid || ack_hit) begin
        m_data  = b;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else begin
      m_ferr = 1'b1;
    end
    expq.push_back(snap());
    if (ack_hit) begin
      fork
        begin
          repeat (ACK_AT) @(posedge clk);
          #1 rx_ack = 1'b1;
          @(posedge clk);
          #1 rx_ack = 1'b0;
        end
      join_none
    end
    UART_RX = 1'b0;
    bit_time(1);
    for (int i = 0; i < 8; i++) begin
      UART_RX = b[i];
      bit_time(1);
    end
    if (stop_low == 0) begin
      UART_RX = 1'b1;
      bit_time(1);
    end else begin
      UART_RX = 1'b0;
      bit_time(stop_low);
      UART_RX = 1'b1;
    end
    bit_time(gap);
  endtask

  // Monitor: each return to idle presents a frame outcome to the scoreboard.
  initial begin : monitor
    logic busy_prev;
    exp_t e;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_prev = 1'b0;
      end else begin
        if (busy_prev && !busy) begin
          checks++;
          if (expq.size() == 0) begin
            failures++;
            $display("FAIL frame_end: unexpected end of frame, data=%0h valid=%0b", rx_data, rx_valid);
          end else begin
            e = expq.pop_front();
            if ({rx_data, rx_valid, frame_err, overrun} !== e) begin
              failures++;
              $display("FAIL frame_result: got data=%0h v=%0b fe=%0b ov=%0b expected data=%0h v=%0b fe=%0b ov=%0b",
                       rx_data, rx_valid, frame_err, overrun, e.data, e.valid, e.ferr, e.ovr);
            end
          end
        end
        busy_prev = busy;
      end
    end
  end

  initial begin : stim
    int lat;
    int nbusy;
    logic [7:0] b;
    bit hit;
    int bad;
    int gap;

    repeat (3) @(negedge clk);
    chk("reset_outputs", {23'd0, rx_data, rx_valid, frame_err, overrun, busy}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    bit_time(1);

    // 1: single byte and start-edge-to-valid latency
    lat = 0;
    fork
      send_frame(8'hA5, 0, 1'b0, 1);
      begin
        while (lat < 400) begin
          @(negedge clk);
          if (rx_valid) break;
          lat++;
        end
      end
    join
    checks++;
    if (lat < 152 || lat > 158) begin
      failures++;
      $display("FAIL valid_latency: got %0d cycles expected about %0d", lat, ACK_AT);
    end
    chk("a5_data", {24'd0, rx_data}, {24'd0, m_data});
    pulse_ack();

    // 2: back-to-back without ack -> overrun, old byte kept
    send_frame(8'h3C, 0, 1'b0, 0);
    send_frame(8'hC3, 0, 1'b0, 1);
    chk("overrun_set", {31'd0, overrun}, {31'd0, m_ovr});
    pulse_clr();
    @(negedge clk);
    chk("overrun_cleared", {31'd0, overrun}, {31'd0, m_ovr});
    @(posedge clk); #1;
    pulse_ack();
    @(negedge clk);
    chk("ack_clears_valid", {31'd0, rx_valid}, {31'd0, m_valid});
    @(posedge clk); #1;

    // 3: short low glitch is rejected
    expq.push_back(snap());
    nbusy = 0;
    fork
      begin
        UART_RX = 1'b0;
        repeat (4) @(posedge clk);
        #1 UART_RX = 1'b1;
        repeat (36) @(posedge clk);
        #1;
      end
      begin
        repeat (40) begin
          @(negedge clk);
          if (busy) nbusy++;
        end
      end
    join
    checks++;
    if (nbusy < HALF - 1 || nbusy > HALF + 1) begin
      failures++;
      $display("FAIL glitch_busy: got %0d busy cycles expected about %0d", nbusy, HALF);
    end

    // 4: stop held low for three bit times, then a clean frame
    fork
      send_frame(8'h55, 3, 1'b0, 2);
      begin
        repeat (186) @(negedge clk);
        chk("wait_high_busy", {30'd0, busy, frame_err}, 32'd3);
        repeat (15) @(negedge clk);
        chk("wait_high_exit", {31'd0, busy}, 32'd0);
      end
    join
    send_frame(8'h0F, 0, 1'b0, 1);
    chk("after_break_data", {24'd0, rx_data}, {24'd0, m_data});
    pulse_clr();
    pulse_ack();

    // 5: ack lands on the commit cycle of the second byte
    send_frame(8'h7E, 0, 1'b0, 0);
    send_frame(8'h81, 0, 1'b1, 1);
    chk("ack_commit", {22'd0, rx_data, rx_valid, overrun}, {22'd0, m_data, m_valid, m_ovr});

    // Randomised traffic against the frame-level model
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(1, 0) == 1) pulse_ack();
      if ($urandom_range(3, 0) == 0) pulse_clr();
      b   = 8'($urandom);
      bad = ($urandom_range(6, 0) == 0) ? 1 : 0;
      hit = (bad == 0) && ($urandom_range(4, 0) == 0);
      gap = (bad != 0) ? 2 : int'($urandom_range(2, 0));
      send_frame(b, bad, hit, gap);
    end

    // 6: reset in the middle of a data phase
    send_frame(8'hA0, 0, 1'b1, 1);
    UART_RX = 1'b0;
    bit_time(1);
    UART_RX = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("mid_frame_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #2;
    chk("async_reset", {23'd0, rx_data, rx_valid, frame_err, overrun, busy}, 32'd0);
    m_data = 8'h00; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    bit_time(1);
    send_frame(8'h12, 0, 1'b0, 1);
    chk("post_reset_data", {21'd0, rx_data, rx_valid, frame_err, overrun, busy},
        {21'd0, 8'h12, 1'b1, 1'b0, 1'b0, 1'b0});

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drain", expq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
